multicycle_ctrl: RTL

- Main control FSM for the multicycle RV32I core.
- Decodes op/funct3/funct7b5 from the instruction register and sequences PC, instruction memory, register file, ALU and immediate extender one state per clock.
- Drives ImmSrc for the extend unit, plus all mux selects and write enables, and keeps a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Sequences fetch, decode, execute, memory and writeback one state per clock,
// drives every datapath mux select and write enable, and counts retired
// instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [2:0]       ImmSrc,
    output logic             RegWrite,
    output logic             IllegalInstr,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_BEQ      = 4'd9,
        S_ALUWB    = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_instr_count;

    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_retire;

    // State register; reset returns to FETCH at once, without waiting for a clock.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = S_TRAP;
        case (r_state)
            S_FETCH:    w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_LUI:       w_next_state = S_LUI;
                    default:      w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL:      w_next_state = S_ALUWB;
            S_MEMWB,
            S_MEMWRITE,
            S_ALUWB,
            S_BEQ,
            S_LUI:      w_next_state = S_FETCH;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_TRAP;
        endcase
    end

    // Moore outputs for each state; enables are gated with reset further down.
    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_op     = 2'b00;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        IllegalInstr = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
            end
            S_LUI: begin
                ResultSrc   = 2'b11;
                w_reg_write = 1'b1;
            end
            S_TRAP:     IllegalInstr = 1'b1;
            default:    IllegalInstr = 1'b0;
        endcase
    end

    // ALU decoder: ALUOp from the FSM refined by funct3/funct7b5.
    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format select, decoded from op in every state.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BEQ:  ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
    end

    // Write enables are held off while reset is asserted so an abandoned
    // instruction cannot disturb architectural state.
    assign PCWrite  = rst_n & (w_pc_update | (w_branch & Zero));
    assign IRWrite  = rst_n & w_ir_write;
    assign RegWrite = rst_n & w_reg_write;
    assign MemWrite = rst_n & w_mem_write;

    assign w_retire = (r_state == S_MEMWB)  || (r_state == S_MEMWRITE) ||
                      (r_state == S_ALUWB)  || (r_state == S_BEQ)      ||
                      (r_state == S_LUI);

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign State      = r_state;
    assign InstrCount = r_instr_count;

endmodule
